// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit frame controller (start, data LSB first, optional parity, stop).
module uart_tx_fsm #(
  parameter int Data_Len = 8,
  parameter int CountLen = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [Data_Len-1:0] P_DATA,
  input  logic                Data_Valid,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  input  logic                ser_data,
  input  logic                ser_done,
  output logic                ser_en,
  output logic                TX_OUT,
  output logic                busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CountLen-1:0] LAST_BIT = CountLen'(Data_Len - 1);

  logic [2:0]          state;
  logic [Data_Len-1:0] data_q;
  logic                par_en_q;
  logic                par_typ_q;
  logic [CountLen-1:0] bit_cnt;
  logic                par_bit;
  logic                accept;

  assign accept = (state == IDLE) && Data_Valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      bit_cnt   <= '0;
      ser_en    <= 1'b0;
    end else begin
      // A completion flag wins over a fresh accept in the same cycle.
      if (ser_done) begin
        ser_en <= 1'b0;
      end else if (accept) begin
        ser_en <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (Data_Valid) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            state     <= START;
          end
        end
        START: begin
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: state <= STOP;
        STOP:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign par_bit = par_typ_q ? ~(^data_q) : (^data_q);

  always_comb begin
    TX_OUT = 1'b1;
    case (state)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser_data;
      PARITY:  TX_OUT = par_bit;
      default: TX_OUT = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - scoreboard bench for uart_tx_fsm with a behavioural serializer and frame model.
module tb_uart_tx_fsm;
  localparam int DL = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DL-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          ser_data;
  logic          ser_done;
  logic          ser_en;
  logic          TX_OUT;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc_no = 0;
  bit mon_on = 1'b0;

  typedef struct packed {
    logic tx;
    logic bsy;
    logic sen;
  } exp_t;

  exp_t exp_q[$];

  uart_tx_fsm #(.Data_Len(DL), .CountLen(4)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data),
    .ser_done(ser_done), .ser_en(ser_en), .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: a frame is accepted when idle, then occupies 2+DL+PAR_EN cycles.
  logic [DL-1:0] ser_byte = '0;
  int remaining = 0;
  always @(posedge CLK) begin
    if (RST) begin
      exp_q.delete();
      remaining = 0;
    end else if (remaining > 0) begin
      remaining = remaining - 1;
    end else if (Data_Valid) begin
      logic [DL-1:0] d;
      int len;
      logic par;
      exp_t e;
      d = P_DATA;
      len = 2 + DL + (PAR_EN ? 1 : 0);
      par = logic'($countones(d) % 2) ^ PAR_TYP;
      for (int k = 0; k < len; k++) begin
        if (k == 0) e.tx = 1'b0;
        else if (k <= DL) e.tx = d[k-1];
        else if (PAR_EN && k == DL + 1) e.tx = par;
        else e.tx = 1'b1;
        e.bsy = 1'b1;
        e.sen = (k <= DL + 1);
        exp_q.push_back(e);
      end
      remaining = len;
      ser_byte <= d;
    end
  end

  // Behavioural serializer: loads on ser_en rising, one bit per cycle, then a done pulse.
  logic [DL-1:0] sreg;
  int  sidx;
  bit  sactive;
  logic sprev;
  always @(posedge CLK) begin
    if (RST) begin
      ser_data <= 1'b0;
      ser_done <= 1'b0;
      sreg     <= '0;
      sidx     <= 0;
      sactive  <= 1'b0;
      sprev    <= 1'b0;
    end else begin
      ser_done <= 1'b0;
      if (ser_en && !sprev) begin
        sreg     <= ser_byte;
        ser_data <= ser_byte[0];
        sidx     <= 1;
        sactive  <= 1'b1;
      end else if (sactive) begin
        if (sidx < DL) begin
          ser_data <= sreg[sidx];
          sidx     <= sidx + 1;
        end else begin
          ser_done <= 1'b1;
          sactive  <= 1'b0;
        end
      end
      sprev <= ser_en;
    end
  end

  // Monitor: every cycle pops the expected line state, or expects idle when nothing is queued.
  always @(negedge CLK) begin
    if (mon_on) begin
      exp_t e;
      cyc_no++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{tx: 1'b1, bsy: 1'b0, sen: 1'b0};
      tests++;
      if (TX_OUT !== e.tx) begin
        fails++;
        $display("FAIL tx_out cycle %0d: got %b want %b", cyc_no, TX_OUT, e.tx);
      end
      tests++;
      if (busy !== e.bsy) begin
        fails++;
        $display("FAIL busy cycle %0d: got %b want %b", cyc_no, busy, e.bsy);
      end
      tests++;
      if (ser_en !== e.sen) begin
        fails++;
        $display("FAIL ser_en cycle %0d: got %b want %b", cyc_no, ser_en, e.sen);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [DL-1:0] d, input logic pe, input logic pt);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  initial begin
    cycles(2);
    mon_on = 1'b1;
    RST = 1'b0;
    cycles(2);

    send(8'hA5, 1'b1, 1'b0);
    cycles(12);
    send(8'hA5, 1'b1, 1'b1);
    cycles(12);
    send(8'h3C, 1'b0, 1'b0);
    cycles(11);

    // Requests and data changes during a frame must be ignored.
    send(8'h00, 1'b1, 1'b0);
    cycles(1);
    P_DATA = 8'hFF;
    Data_Valid = 1'b1;
    cycles(11);
    Data_Valid = 1'b0;
    cycles(13);

    // Reset in the third DATA cycle, then reset colliding with a request in IDLE.
    send(8'h55, 1'b0, 1'b0);
    cycles(3);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    cycles(2);
    RST = 1'b1;
    Data_Valid = 1'b1;
    cycles(1);
    RST = 1'b0;
    Data_Valid = 1'b0;
    cycles(2);
    send(8'h81, 1'b1, 1'b1);
    cycles(13);

    for (int it = 0; it < 40; it++) begin
      send(DL'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; c < 12; c++) begin
        P_DATA = DL'($urandom);
        PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom);
        Data_Valid = ($urandom_range(0, 3) == 0);
        cycles(1);
      end
      Data_Valid = 1'b0;
      cycles($urandom_range(0, 2));
    end
    Data_Valid = 1'b0;
    cycles(16);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame controller for the UART transmit path. It accepts a parallel byte with a Data_Valid strobe and sequences the serializer. It builds the frame: start bit, Data_Len data bits LSB first, an optional parity bit and a stop bit. It drives the line output TX_OUT directly. One CLK cycle equals one bit time; CLK is the baud-tick clock.

## Interface
- Data_Len, 8: data bits per frame; also the width of P_DATA.
- CountLen, 4: width of the internal bit counter; must satisfy 2^CountLen > Data_Len.
- CLK  in  1  bit-rate clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- P_DATA  in  Data_Len  byte to send; sampled only in the accept cycle.
- Data_Valid  in  1  request strobe; accepted only in IDLE.
- PAR_EN  in  1  1 = parity bit present; latched at accept.
- PAR_TYP  in  1  0 = even, 1 = odd; latched at accept.
- ser_data  in  1  serial bit from serializer; registered there and valid one cycle after ser_en rises.
- ser_done  in  1  serializer completion flag.
- ser_en  out  1  serializer enable; registered.
- TX_OUT  out  1  UART line; idles high.
- busy  out  1  high while a frame is in progress.

## Operation
- Five states: IDLE, START, DATA, PARITY, STOP. State, data latch, parity latches, bit counter and ser_en are registered.
- TX_OUT is decoded from the registered state:
  - IDLE = 1, START = 0, STOP = 1.
  - DATA = ser_data.
  - PARITY = par_bit.
- busy = 1 in every state except IDLE.
- IDLE:
  - If Data_Valid = 1, latch P_DATA, PAR_EN and PAR_TYP; set ser_en <= 1; go to START.
  - Otherwise stay in IDLE.
- START: lasts one cycle; clear the bit counter; go to DATA.
- DATA:
  - Increment the bit counter each cycle.
  - After exactly Data_Len DATA cycles, go to PARITY if latched PAR_EN = 1, else to STOP.
  - The exit is counter-driven; ser_done is not used for sequencing.
- PARITY:
  - Lasts one cycle.
  - par_bit = XOR-reduce of the latched data when PAR_TYP = 0 (even).
  - par_bit = XNOR-reduce of the latched data when PAR_TYP = 1 (odd).
- STOP: lasts one cycle, then go to IDLE. There is no back-to-back accept from STOP; a new frame needs at least one IDLE cycle.
- ser_en:
  - Set at the accept edge.
  - Cleared at the first edge where ser_done = 1 is sampled, in any state.
  - Clearing has priority over setting in the same cycle.
- Data_Valid is ignored while busy = 1; no queueing, no error flag.
- P_DATA, PAR_EN and PAR_TYP changes after accept do not affect the frame in progress.

## Timing
- Reset values:
  - state = IDLE, TX_OUT = 1, busy = 0, ser_en = 0.
  - Data latch = 0, bit counter = 0, parity latches = 0.
- RST dominates every other input, including Data_Valid, in the same cycle.
- RST asserted mid-frame: next cycle TX_OUT = 1, busy = 0, ser_en = 0. The partial frame is abandoned.
- Latency: the Data_Valid edge is followed by the start bit on TX_OUT in the next cycle.
- Frame length is 2 + Data_Len + PAR_EN cycles: 11 with parity, 10 without (Data_Len = 8).
- The minimum accept-to-accept period is frame length + 1.
- The i-th DATA cycle (i = 0 .. Data_Len-1) shows bit i on TX_OUT.
- busy rises with START and falls on the edge leaving STOP.
- ser_en is high from START until one cycle after ser_done is first sampled high. It is low again before the following IDLE accept, so the serializer reloads P_DATA.

## Test plan
- Even parity: reset, then P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, one-cycle Data_Valid. TX_OUT over 11 cycles must be 0,1,0,1,0,0,1,0,1,0,1, then 1 idle. busy must be high for exactly 11 cycles.
- Odd parity: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 1. Parity cycle TX_OUT = 1; all other bits as in the even case.
- No parity: P_DATA = 0x3C, PAR_EN = 0. TX_OUT = 0,0,0,1,1,1,1,0,0,1 (10 cycles); there is no PARITY state.
- Mid-frame requests: hold Data_Valid = 1 and change P_DATA to 0xFF during DATA of a 0x00 frame. The frame is unchanged. A second frame of 0xFF starts only after one IDLE cycle.
- Reset mid-frame: assert RST in the 3rd DATA cycle. Next cycle TX_OUT = 1, busy = 0, ser_en = 0. A fresh 0x81 frame sent afterwards must be correct.
- Serializer handshake: ser_done pulses after the last DATA cycle. ser_en must fall on the edge after ser_done is sampled and stay 0 through IDLE.
